fec_dec_ctrl: RTL

Sequencer for the 2D-parity FEC `decoder`. It accepts one coded frame (data matrix plus row and column parity) over a valid/ready handshake and launches the decoder with a one-cycle start pulse. It waits for the decoder's `complete` rising edge, or a timeout, then presents the corrected matrix and a 2-bit status over a second valid/ready handshake. It sits between the receive framer and the decoder instance and owns all decoder start/complete sequencing.

---
 rtl/fec_dec_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fec_dec_ctrl.sv
// fec_dec_ctrl: start/complete sequencer wrapped around the 2D-parity FEC decoder.
// Statistics counters are built only when FEC_DEC_STATS_EN is defined.
module fec_dec_ctrl #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH*DEPTH-1:0]   in_data,
    input  logic [DEPTH-1:0]         in_row_p,
    input  logic [WIDTH-1:0]         in_col_p,
    output logic [WIDTH*DEPTH-1:0]   dec_data,
    output logic [DEPTH-1:0]         dec_row_p,
    output logic [WIDTH-1:0]         dec_col_p,
    output logic                     dec_start,
    input  logic                     dec_complete,
    input  logic                     dec_err_det,
    input  logic                     dec_err_corr,
    input  logic [WIDTH*DEPTH-1:0]   dec_data_corr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH*DEPTH-1:0]   out_data,
    output logic [1:0]               out_status,
    input  logic                     stats_clr,
    output logic [CNT_W-1:0]         cnt_frames,
    output logic [CNT_W-1:0]         cnt_corr,
    output logic [CNT_W-1:0]         cnt_uncorr,
    output logic [CNT_W-1:0]         cnt_timeout
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_HOLD   = 2'd3;

    localparam logic [1:0] ST_CLEAN   = 2'b00;
    localparam logic [1:0] ST_CORR    = 2'b01;
    localparam logic [1:0] ST_UNCORR  = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    localparam int              TO_W    = 16;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [1:0]             state_q, state_d;
    logic                   cmp_q;
    logic                   cmp_edge;
    logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
    logic [WIDTH*DEPTH-1:0] dec_data_q, dec_data_d;
    logic [DEPTH-1:0]       dec_row_p_q, dec_row_p_d;
    logic [WIDTH-1:0]       dec_col_p_q, dec_col_p_d;
    logic [WIDTH*DEPTH-1:0] out_data_q, out_data_d;
    logic [1:0]             out_status_q, out_status_d;

    // Only a fresh rising edge counts, so a level held over from the last frame is ignored.
    assign cmp_edge = dec_complete & ~cmp_q;

    always_comb begin
        state_d      = state_q;
        to_cnt_d     = to_cnt_q;
        dec_data_d   = dec_data_q;
        dec_row_p_d  = dec_row_p_q;
        dec_col_p_d  = dec_col_p_q;
        out_data_d   = out_data_q;
        out_status_d = out_status_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dec_data_d  = in_data;
                    dec_row_p_d = in_row_p;
                    dec_col_p_d = in_col_p;
                    state_d     = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                to_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                if (cmp_edge) begin
                    out_data_d = dec_data_corr;
                    if (!dec_err_det) begin
                        out_status_d = ST_CLEAN;
                    end else if (dec_err_corr) begin
                        out_status_d = ST_CORR;
                    end else begin
                        out_status_d = ST_UNCORR;
                    end
                    state_d = S_HOLD;
                end else if (to_cnt_q == TO_LAST) begin
                    out_data_d   = dec_data_q;
                    out_status_d = ST_TIMEOUT;
                    state_d      = S_HOLD;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cmp_q        <= 1'b0;
            to_cnt_q     <= '0;
            dec_data_q   <= '0;
            dec_row_p_q  <= '0;
            dec_col_p_q  <= '0;
            out_data_q   <= '0;
            out_status_q <= '0;
        end else begin
            state_q      <= state_d;
            cmp_q        <= dec_complete;
            to_cnt_q     <= to_cnt_d;
            dec_data_q   <= dec_data_d;
            dec_row_p_q  <= dec_row_p_d;
            dec_col_p_q  <= dec_col_p_d;
            out_data_q   <= out_data_d;
            out_status_q <= out_status_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign dec_start  = (state_q == S_LAUNCH);
    assign out_valid  = (state_q == S_HOLD);
    assign dec_data   = dec_data_q;
    assign dec_row_p  = dec_row_p_q;
    assign dec_col_p  = dec_col_p_q;
    assign out_data   = out_data_q;
    assign out_status = out_status_q;

`ifdef FEC_DEC_STATS_EN
    logic             out_hs;
    logic [CNT_W-1:0] frames_q, corr_q, uncorr_q, timeout_q;

    assign out_hs = out_valid & out_ready;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr) begin
            frames_q  <= '0;
            corr_q    <= '0;
            uncorr_q  <= '0;
            timeout_q <= '0;
        end else if (out_hs) begin
            frames_q <= sat_inc(frames_q);
            if (out_status_q == ST_CORR)    corr_q    <= sat_inc(corr_q);
            if (out_status_q == ST_UNCORR)  uncorr_q  <= sat_inc(uncorr_q);
            if (out_status_q == ST_TIMEOUT) timeout_q <= sat_inc(timeout_q);
        end
    end

    assign cnt_frames  = frames_q;
    assign cnt_corr    = corr_q;
    assign cnt_uncorr  = uncorr_q;
    assign cnt_timeout = timeout_q;
`else
    logic unused_stats_clr;

    assign unused_stats_clr = stats_clr;
    assign cnt_frames       = '0;
    assign cnt_corr         = '0;
    assign cnt_uncorr       = '0;
    assign cnt_timeout      = '0;
`endif

endmodule
